seven_seg_scan_driver: RTL

- Display back-end for the seven-segment user project; sits directly downstream of the seconds counter and Wishbone wrapper.
- Accepts a 16-bit binary value on a load strobe and converts it to 4 BCD digits with a sequential shift-add-3 engine.
- Time-multiplexes the 4 digits onto one shared 7-segment bus plus 4 digit enables for the io pads.
- The wrapper gates these outputs onto io_out when the project is active.

---
 rtl/seven_seg_scan_driver.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
//   Converts a 16-bit binary value to four BCD digits with a sequential
//   shift-add-3 engine. The digits are then time-multiplexed onto one shared
//   7-segment bus with four one-hot digit enables.
//
//   Optional build macro: SEVEN_SEG_BLANK_LEADING_ZERO_EN
//     When defined, digits above the most-significant non-zero digit are
//     driven dark. Digit 0 is never blanked.
//     When undefined, all four digits are always decoded.
//
//   Parameters:
//     SCAN_DIV  clk cycles each digit stays enabled (1..65535)
//     DIGITS    number of scanned digits, must be 4
//
//   Ports:
//     clk       system clock
//     reset_n   asynchronous active-low reset
//     value_in  binary value, sampled when load is seen in IDLE
//     load      single-cycle load strobe
//     busy      high while a conversion is in flight
//     overflow  last accepted value_in was above 9999 (display clamped)
//     led_out   segments {g,f,e,d,c,b,a}, active-high, registered
//     digit_en  one-hot digit enable, bit 0 = ones digit, registered
module seven_seg_scan_driver #(
    parameter int SCAN_DIV = 1000,
    parameter int DIGITS   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] value_in,
    input  logic        load,
    output logic        busy,
    output logic        overflow,
    output logic [6:0]  led_out,
    output logic [3:0]  digit_en
);

    localparam logic [15:0] LP_PRESC_MAX = 16'(SCAN_DIV - 1);
    localparam logic [1:0]  LP_IDX_MAX   = 2'(DIGITS - 1);
    localparam logic [15:0] LP_CLAMP     = 16'd9999;

    typedef enum logic {IDLE, CONVERT} state_t;

    state_t      r_state;
    logic [15:0] r_bin;
    logic [15:0] r_bcd;
    logic [3:0]  r_cnt;
    logic [15:0] r_disp;
    logic [15:0] r_presc;
    logic [1:0]  r_idx;

    logic [15:0] w_bcd_adj;
    logic [15:0] w_bcd_next;
    logic [3:0]  w_nib;
    logic        w_blank;

    // Add-3 correction on every nibble that would reach 10+ after doubling.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    assign w_bcd_next = {w_bcd_adj[14:0], r_bin[15]};

    // Conversion FSM. The display register is written only on the 16th
    // shift, so the scan never sees a partially converted value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            busy     <= 1'b0;
            overflow <= 1'b0;
            r_bin    <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_disp   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_bin    <= (value_in > LP_CLAMP) ? LP_CLAMP : value_in;
                        overflow <= (value_in > LP_CLAMP);
                        r_bcd    <= '0;
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                        r_state  <= CONVERT;
                    end
                end
                CONVERT: begin
                    r_bcd <= w_bcd_next;
                    r_bin <= {r_bin[14:0], 1'b0};
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_disp  <= w_bcd_next;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Scan prescaler and digit index; free-running, independent of the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (r_presc == LP_PRESC_MAX) begin
            r_presc <= '0;
            r_idx   <= (r_idx == LP_IDX_MAX) ? 2'd0 : r_idx + 2'd1;
        end else begin
            r_presc <= r_presc + 16'd1;
        end
    end

    assign w_nib = r_disp[{r_idx, 2'b00} +: 4];

`ifdef SEVEN_SEG_BLANK_LEADING_ZERO_EN
    // A digit is dark when it and every digit above it are zero.
    always_comb begin
        w_blank = 1'b0;
        case (r_idx)
            2'd1:    w_blank = (r_disp[15:4]  == 12'd0);
            2'd2:    w_blank = (r_disp[15:8]  == 8'd0);
            2'd3:    w_blank = (r_disp[15:12] == 4'd0);
            default: w_blank = 1'b0;
        endcase
    end
`else
    assign w_blank = 1'b0;
`endif

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    // Registered pad outputs, one cycle behind the index / display register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit_en <= 4'b0001;
            led_out  <= 7'h3F;
        end else begin
            digit_en <= 4'b0001 << r_idx;
            led_out  <= w_blank ? 7'h00 : seg_decode(w_nib);
        end
    end

endmodule
